// File: rtl/scaler_div_arbiter.sv
// Shared serial restoring reciprocal engine (2^(DIVIDEND_WIDTH-1)/divisor), round-robin shared by V and H cfg requesters.
// Optional build macro SCALER_DIV_CACHE_EN adds a per-requester last-result cache that short-cuts repeat divisors.
module scaler_div_arbiter #(
    parameter int DIVIDEND_WIDTH = 18,
    parameter int DIVISOR_WIDTH  = 12
) (
    input  logic                      SYS_CLK,
    input  logic                      nRST,
    input  logic                      v_req_i,
    input  logic [DIVISOR_WIDTH-1:0]  v_divisor_i,
    input  logic                      h_req_i,
    input  logic [DIVISOR_WIDTH-1:0]  h_divisor_i,
    output logic                      v_done_o,
    output logic [DIVIDEND_WIDTH-1:0] v_quotient_o,
    output logic                      h_done_o,
    output logic [DIVIDEND_WIDTH-1:0] h_quotient_o,
    output logic                      busy_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int CNT_W = $clog2(DIVIDEND_WIDTH);
    localparam int REM_W = DIVISOR_WIDTH + 1;

    localparam logic [DIVIDEND_WIDTH-1:0] DIVIDEND  = {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}};
    localparam logic [DIVIDEND_WIDTH-1:0] ALL_ONES  = {DIVIDEND_WIDTH{1'b1}};
    localparam logic [CNT_W-1:0]          CNT_START = CNT_W'(DIVIDEND_WIDTH - 1);

    logic [1:0]                state_r;
    logic                      prio_r;      // 0: V owns priority, 1: H
    logic                      gnt_r;       // 0: V granted, 1: H granted
    logic [DIVISOR_WIDTH-1:0]  div_r;
    logic [REM_W-1:0]          rem_r;
    logic [DIVIDEND_WIDTH-1:0] quo_r;
    logic [CNT_W-1:0]          cnt_r;
    logic                      v_done_r;
    logic                      h_done_r;
    logic [DIVIDEND_WIDTH-1:0] v_quo_r;
    logic [DIVIDEND_WIDTH-1:0] h_quo_r;
    logic                      busy_r;

    logic                      req_any_s;
    logic                      gnt_s;
    logic [DIVISOR_WIDTH-1:0]  sel_div_s;
    logic [REM_W-1:0]          rem_shift_s;
    logic                      ge_s;
    logic [REM_W-1:0]          rem_next_s;
    logic [DIVIDEND_WIDTH-1:0] result_s;
    logic                      cache_hit_s;
    logic [DIVIDEND_WIDTH-1:0] cache_quo_s;

`ifdef SCALER_DIV_CACHE_EN
    logic                      v_cache_valid_r;
    logic [DIVISOR_WIDTH-1:0]  v_cache_div_r;
    logic [DIVIDEND_WIDTH-1:0] v_cache_quo_r;
    logic                      h_cache_valid_r;
    logic [DIVISOR_WIDTH-1:0]  h_cache_div_r;
    logic [DIVIDEND_WIDTH-1:0] h_cache_quo_r;
`endif

    // Grant selection: single requester wins outright, contention goes to the priority owner.
    always_comb begin
        req_any_s = v_req_i | h_req_i;
        if (v_req_i && h_req_i) begin
            gnt_s = prio_r;
        end else begin
            gnt_s = h_req_i;
        end
        sel_div_s = gnt_s ? h_divisor_i : v_divisor_i;
    end

    // Cache lookup against the divisor that would be granted this cycle.
    always_comb begin
`ifdef SCALER_DIV_CACHE_EN
        if (gnt_s) begin
            cache_hit_s = h_cache_valid_r && (h_cache_div_r == sel_div_s);
            cache_quo_s = h_cache_quo_r;
        end else begin
            cache_hit_s = v_cache_valid_r && (v_cache_div_r == sel_div_s);
            cache_quo_s = v_cache_quo_r;
        end
`else
        cache_hit_s = 1'b0;
        cache_quo_s = '0;
`endif
    end

    // One restoring step: quotient bits shift in at the LSB while dividend bits leave the MSB.
    always_comb begin
        rem_shift_s = {rem_r[REM_W-2:0], quo_r[DIVIDEND_WIDTH-1]};
        ge_s        = (rem_shift_s >= {1'b0, div_r});
        if (ge_s) begin
            rem_next_s = rem_shift_s - {1'b0, div_r};
        end else begin
            rem_next_s = rem_shift_s;
        end
        if (div_r == '0) begin
            result_s = ALL_ONES;
        end else begin
            result_s = quo_r;
        end
    end

    // Main FSM, divider datapath and registered outputs.
    always_ff @(posedge SYS_CLK or negedge nRST) begin
        if (!nRST) begin
            state_r  <= ST_IDLE;
            prio_r   <= 1'b0;
            gnt_r    <= 1'b0;
            div_r    <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            cnt_r    <= '0;
            v_done_r <= 1'b0;
            h_done_r <= 1'b0;
            v_quo_r  <= '0;
            h_quo_r  <= '0;
            busy_r   <= 1'b0;
`ifdef SCALER_DIV_CACHE_EN
            v_cache_valid_r <= 1'b0;
            v_cache_div_r   <= '0;
            v_cache_quo_r   <= '0;
            h_cache_valid_r <= 1'b0;
            h_cache_div_r   <= '0;
            h_cache_quo_r   <= '0;
`endif
        end else begin
            v_done_r <= 1'b0;
            h_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_any_s) begin
                        gnt_r  <= gnt_s;
                        div_r  <= sel_div_s;
                        busy_r <= 1'b1;
                        if (cache_hit_s) begin
                            quo_r   <= cache_quo_s;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    rem_r   <= '0;
                    quo_r   <= DIVIDEND;
                    cnt_r   <= CNT_START;
                    state_r <= ST_CALC;
                end
                ST_CALC: begin
                    rem_r <= rem_next_s;
                    quo_r <= {quo_r[DIVIDEND_WIDTH-2:0], ge_s};
                    if (cnt_r == '0) begin
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (gnt_r) begin
                        h_quo_r  <= result_s;
                        h_done_r <= 1'b1;
`ifdef SCALER_DIV_CACHE_EN
                        h_cache_valid_r <= 1'b1;
                        h_cache_div_r   <= div_r;
                        h_cache_quo_r   <= result_s;
`endif
                    end else begin
                        v_quo_r  <= result_s;
                        v_done_r <= 1'b1;
`ifdef SCALER_DIV_CACHE_EN
                        v_cache_valid_r <= 1'b1;
                        v_cache_div_r   <= div_r;
                        v_cache_quo_r   <= result_s;
`endif
                    end
                    prio_r  <= ~gnt_r;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign v_done_o     = v_done_r;
    assign h_done_o     = h_done_r;
    assign v_quotient_o = v_quo_r;
    assign h_quotient_o = h_quo_r;
    assign busy_o       = busy_r;

endmodule

// File: tb/tb_scaler_div_arbiter.sv
// Self-checking bench for scaler_div_arbiter: per-requester scoreboards of expected quotients, latency and order checks.
module tb_scaler_div_arbiter;

`ifdef SCALER_DIV_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        SYS_CLK;
    logic        nRST;
    logic        v_req_i;
    logic [11:0] v_divisor_i;
    logic        h_req_i;
    logic [11:0] h_divisor_i;
    logic        v_done_o;
    logic [17:0] v_quotient_o;
    logic        h_done_o;
    logic [17:0] h_quotient_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    logic [17:0] v_exp_q[$];
    logic [17:0] h_exp_q[$];

    scaler_div_arbiter dut (
        .SYS_CLK      (SYS_CLK),
        .nRST         (nRST),
        .v_req_i      (v_req_i),
        .v_divisor_i  (v_divisor_i),
        .h_req_i      (h_req_i),
        .h_divisor_i  (h_divisor_i),
        .v_done_o     (v_done_o),
        .v_quotient_o (v_quotient_o),
        .h_done_o     (h_done_o),
        .h_quotient_o (h_quotient_o),
        .busy_o       (busy_o)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    function automatic logic [17:0] model(input logic [11:0] d);
        if (d == 12'd0) return 18'h3FFFF;
        return 18'(32'd131072 / {20'd0, d});
    endfunction

    task automatic tick();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        v_req_i = 1'b0; h_req_i = 1'b0;
        v_divisor_i = 12'd0; h_divisor_i = 12'd0;
        repeat (3) @(posedge SYS_CLK);
        #3 nRST = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        checks++; if ({v_done_o, h_done_o} !== 2'b00) begin errors++; $display("FAIL reset_done got %b exp 00", {v_done_o, h_done_o}); end
        checks++; if (v_quotient_o !== 18'd0) begin errors++; $display("FAIL reset_vq got %0d exp 0", v_quotient_o); end
        checks++; if (h_quotient_o !== 18'd0) begin errors++; $display("FAIL reset_hq got %0d exp 0", h_quotient_o); end
    endtask

    // Single-requester op: latency, quotient, pulse width and isolation of the other side.
    task automatic run_single(input bit is_h, input logic [11:0] div, input int exp_lat, input string name);
        logic [17:0] other_before, exp, got;
        int n;
        bit seen, stray;
        n = 0; seen = 1'b0; stray = 1'b0;
        if (is_h) h_exp_q.push_back(model(div)); else v_exp_q.push_back(model(div));
        other_before = is_h ? v_quotient_o : h_quotient_o;
        if (is_h) begin h_req_i = 1'b1; h_divisor_i = div; end
        else begin v_req_i = 1'b1; v_divisor_i = div; end
        @(posedge SYS_CLK);
        while (!seen && n < 100) begin
            tick();
            n++;
            if (is_h ? h_done_o : v_done_o) seen = 1'b1;
            if (is_h ? v_done_o : h_done_o) stray = 1'b1;
        end
        v_req_i = 1'b0; h_req_i = 1'b0;
        got = is_h ? h_quotient_o : v_quotient_o;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL %s_timeout no done within 100 cycles", name);
        end else begin
            checks++; if (n != exp_lat) begin errors++; $display("FAIL %s_latency got %0d exp %0d", name, n, exp_lat); end
            exp = is_h ? h_exp_q.pop_front() : v_exp_q.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL %s_quotient got %0d exp %0d", name, got, exp); end
        end
        checks++; if (stray) begin errors++; $display("FAIL %s_stray_done other requester pulsed got 1 exp 0", name); end
        checks++;
        if ((is_h ? v_quotient_o : h_quotient_o) !== other_before) begin
            errors++; $display("FAIL %s_other_quotient got %0d exp %0d", name, is_h ? v_quotient_o : h_quotient_o, other_before);
        end
        tick();
        checks++; if ({v_done_o, h_done_o} !== 2'b00) begin errors++; $display("FAIL %s_pulse_width got %b exp 00", name, {v_done_o, h_done_o}); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL %s_idle_busy got %b exp 0", name, busy_o); end
    endtask

    task automatic test_v_only();
        run_single(1'b0, 12'd1080, 20, "v1080");
    endtask

    task automatic test_h_only();
        run_single(1'b1, 12'd1920, 20, "h1920");
        run_single(1'b1, 12'd1, 20, "h1");
    endtask

    task automatic test_div_zero();
        run_single(1'b1, 12'd0, 20, "h0");
    endtask

    task automatic test_contention();
        int n, nv, nh;
        logic [17:0] got;
        do_reset();
        v_exp_q.push_back(model(12'd720));
        h_exp_q.push_back(model(12'd1280));
        v_req_i = 1'b1; v_divisor_i = 12'd720;
        h_req_i = 1'b1; h_divisor_i = 12'd1280;
        n = 0; nv = -1; nh = -1;
        @(posedge SYS_CLK);
        while ((nv < 0 || nh < 0) && n < 200) begin
            tick();
            n++;
            if (v_done_o) begin nv = n; got = v_quotient_o; v_req_i = 1'b0;
                checks++; if (got !== v_exp_q.pop_front()) begin errors++; $display("FAIL both_vq got %0d exp 182", got); end
            end
            if (h_done_o) begin nh = n; got = h_quotient_o; h_req_i = 1'b0;
                checks++; if (got !== h_exp_q.pop_front()) begin errors++; $display("FAIL both_hq got %0d exp 102", got); end
            end
        end
        v_req_i = 1'b0; h_req_i = 1'b0;
        checks++; if (nv != 20) begin errors++; $display("FAIL both_v_latency got %0d exp 20", nv); end
        checks++; if (nh != 41) begin errors++; $display("FAIL both_h_latency got %0d exp 41", nh); end
        tick();
    endtask

    task automatic test_reset_midop();
        int seen;
        do_reset();
        v_req_i = 1'b1; v_divisor_i = 12'd1080;
        repeat (10) tick();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL midop_busy_before got %b exp 1", busy_o); end
        nRST = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midop_busy_async got %b exp 0", busy_o); end
        v_req_i = 1'b0;
        repeat (2) @(posedge SYS_CLK);
        #3 nRST = 1'b1;
        seen = 0;
        repeat (25) begin tick(); if (v_done_o || h_done_o) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL midop_no_done got %0d exp 0", seen); end
        checks++; if (v_quotient_o !== 18'd0) begin errors++; $display("FAIL midop_vq got %0d exp 0", v_quotient_o); end
    endtask

    // Both requesters held high: grants must alternate V,H,... with at most one idle cycle between ops.
    task automatic test_back_to_back();
        int n, cnt, last;
        bit exp_h;
        logic [17:0] exp;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            v_exp_q.push_back(model(12'd1000));
            h_exp_q.push_back(model(12'd3000));
        end
        v_req_i = 1'b1; v_divisor_i = 12'd1000;
        h_req_i = 1'b1; h_divisor_i = 12'd3000;
        n = 0; cnt = 0; last = 0; exp_h = 1'b0;
        @(posedge SYS_CLK);
        while (cnt < 6 && n < 400) begin
            tick();
            n++;
            if (v_done_o || h_done_o) begin
                checks++;
                if (h_done_o !== exp_h || v_done_o !== !exp_h) begin
                    errors++; $display("FAIL b2b_order op %0d got v=%b h=%b exp h=%b", cnt, v_done_o, h_done_o, exp_h);
                end
                if (h_done_o) begin
                    exp = (h_exp_q.size() > 0) ? h_exp_q.pop_front() : 18'd0;
                    checks++; if (h_quotient_o !== exp) begin errors++; $display("FAIL b2b_hq op %0d got %0d exp %0d", cnt, h_quotient_o, exp); end
                end else begin
                    exp = (v_exp_q.size() > 0) ? v_exp_q.pop_front() : 18'd0;
                    checks++; if (v_quotient_o !== exp) begin errors++; $display("FAIL b2b_vq op %0d got %0d exp %0d", cnt, v_quotient_o, exp); end
                end
                if (cnt > 0) begin
                    checks++; if (n - last > 21) begin errors++; $display("FAIL b2b_gap op %0d got %0d exp <=21", cnt, n - last); end
                end
                last = n; cnt++; exp_h = !exp_h;
            end
        end
        v_req_i = 1'b0; h_req_i = 1'b0;
        checks++; if (cnt != 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", cnt); end
        tick();
    endtask

    task automatic test_cache();
        run_single(1'b0, 12'd1080, 20, "cache_first");
        run_single(1'b0, 12'd1080, CACHE ? 1 : 20, "cache_repeat");
        run_single(1'b0, 12'd1081, 20, "cache_miss");
    endtask

    initial begin
        test_reset();
        test_v_only();
        test_h_only();
        test_div_zero();
        test_contention();
        test_reset_midop();
        test_back_to_back();
        test_cache();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
